seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
// - Display-side inverse of the hex-to-7-segment path: passively watches a multiplexed 7-seg bus (segments + anodes).
// - Per active digit, decodes the settled pattern back to a 4-bit hex nibble; assembles all digits into one word.
// - Sits beside the display driver as an on-chip self-check/readback monitor and as a bench scoreboard source.
// PARAMETERS
// - N_DIGITS       8   digits on the scanned display (1..8)
// - SETTLE_CYCLES  4   consecutive identical synced cycles required before a digit is sampled (>=1)
// - SEG_ACTIVE_LOW 1   1: seg_in/an_in are active-low (board polarity); 0: active-high
// PORTS
// - clk             in   1            system clock
// - rst_n           in   1            asynchronous active-low reset
// - seg_in          in   7            segments, bit6=a .. bit0=g; asynchronous to clk
// - an_in           in   N_DIGITS     digit enables, one-hot when valid; asynchronous to clk
// - value_o         out  4*N_DIGITS   decoded word; nibble i = digit i
// - blank_o         out  N_DIGITS     1 = digit i was dark (all segments off) in the last frame
// - frame_valid_o   out  1            one-cycle pulse: value_o/blank_o/frame_err_o updated
// - frame_err_o     out  1            last frame had an illegal pattern or multi-anode sample
// BEHAVIOUR
// - Reset: value_o=0, blank_o=0, frame_valid_o=0, frame_err_o=0, sync regs=0 (inactive), seen mask=0, FSM=IDLE.
// - Inputs pass through 2-FF synchronizers, then are normalised to active-high (segment on=1, anode on=1).
// - Decode table, on=1, abcdefg:
//   7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F.
//   00=blank (nibble 0, blank=1). Any other code = illegal (nibble 0, error).
// - FSM IDLE: if an != 0 -> SETTLE; load stable counter = 1; latch {seg, an} snapshot.
// - FSM SETTLE: snapshot equal to current -> counter++; differs -> reload snapshot, counter=1.
//   Counter reaches SETTLE_CYCLES -> SAMPLE.
//   an becomes 0 -> IDLE, nothing sampled.
// - FSM SAMPLE (1 cycle):
//   - an one-hot (digit k): write nibble k and blank k into shadow regs; seen[k]=1.
//   - an not one-hot: discard the sample and set the frame error.
//   - Illegal code: still write digit k and set the frame error.
//   - -> HOLD.
// - FSM HOLD: wait until synced {seg, an} != sampled snapshot -> IDLE.
//   The same digit is never sampled twice in one dwell.
// - Frame completes the cycle after seen becomes all-ones:
//   - copy shadow regs to value_o/blank_o; frame_err_o = accumulated error.
//   - pulse frame_valid_o; clear seen and the error accumulator in the same cycle.
// - A digit re-sampled before the frame completes overwrites its shadow nibble (last wins).
// - Latency: input edge -> sample = 2 (sync) + SETTLE_CYCLES + 1 cycles.
// - Latency: last digit sampled -> frame_valid_o = 1 cycle.
// - Reset mid-frame: shadow regs, seen and error are cleared; partial frame is lost; outputs return to reset values.
// - Anodes held 0 indefinitely: FSM stays IDLE; outputs hold the last frame; no pulse.
// STRUCTURE
// - Package seg7_pkg:
//   - localparam logic [6:0] SEG_HEX[16] (table above, on=1) and SEG_BLANK = 7'h00;
//   - typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} scan_state_t.
// - Sub-module seg7_to_hex: combinational; seg[6:0] -> {nibble[3:0], blank, illegal}; table taken from seg7_pkg.
// - Top: synchronizers, settle counter ($clog2(SETTLE_CYCLES+1) bits), FSM, one-hot check, shadow/output regs.
// TESTING
// - Reset: assert rst_n=0 mid-SETTLE -> all outputs 0 immediately (async); no frame_valid_o after release until a full new frame.
// - Round-trip frame: N=8, SETTLE=4, active-low; display driver scans 0x1234ABCD, 16 cycles/digit.
//   -> frame_valid_o pulses once per scan; value_o=32'h1234ABCD; blank_o=0; frame_err_o=0.
// - Short dwell: digit 3 enabled for 3 synced cycles (< SETTLE), others normal.
//   -> no frame_valid_o until digit 3 dwells >=4 cycles.
// - Blank and illegal: digit 0 seg=7'h00 (on=1) -> blank_o[0]=1, nibble 0, frame_err_o=0.
//   Digit 1 seg=7'h01 -> nibble 0, frame_err_o=1 on that frame only; next clean frame -> frame_err_o=0.
// - Multi-anode: an=8'b0000_0011 (on=1) settled -> sample discarded, frame_err_o=1 at frame end.
//   Digits 0/1 keep their previous shadow values.
// - Glitch/overwrite: segment glitch of 1 cycle during settle restarts the count, so only the final stable code is sampled.
//   Digit 2 scanned twice (5 then 9) in one frame -> value_o nibble 2 = 9.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan readback monitor: segment code
// table (abcdefg, segment on = 1) and the scan FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-7-segment encoder: maps an active-high
// abcdefg pattern back to its nibble, flagging dark and unrecognised codes.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       illegal_o
);

    logic [15:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_hit
            assign hit[gi] = (seg_i == SEG_HEX[gi]);
        end
    endgenerate

    always_comb begin
        nibble_o  = 4'h0;
        blank_o   = (seg_i == SEG_BLANK);
        illegal_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                nibble_o = 4'(i);
            end
        end
        illegal_o = !blank_o && (hit == 16'h0000);
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive readback monitor for a multiplexed 7-segment display: waits for each
// digit's pattern to settle, decodes it, and publishes one word per full scan.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [N_DIGITS-1:0]     an_in,
    output logic [4*N_DIGITS-1:0]   value_o,
    output logic [N_DIGITS-1:0]     blank_o,
    output logic                    frame_valid_o,
    output logic                    frame_err_o
);

    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int SNAP_W = 7 + N_DIGITS;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    // Synchronizers reset to the electrically inactive level of the bus.
    localparam logic [6:0]          SEG_OFF_RAW = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF_RAW  = SEG_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

    logic [6:0]              seg_meta_q, seg_sync_q;
    logic [N_DIGITS-1:0]     an_meta_q, an_sync_q;
    logic [6:0]              seg_on;
    logic [N_DIGITS-1:0]     an_on;
    logic [SNAP_W-1:0]       cur;

    scan_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [SNAP_W-1:0]       snap_q, snap_d;
    logic                    sample_go;

    logic [4*N_DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [N_DIGITS-1:0]     shadow_blank_q, shadow_blank_d;
    logic [N_DIGITS-1:0]     seen_q, seen_d;
    logic                    err_acc_q, err_acc_d;
    logic [4*N_DIGITS-1:0]   value_q, value_d;
    logic [N_DIGITS-1:0]     blank_q, blank_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic [6:0]              snap_seg;
    logic [N_DIGITS-1:0]     snap_an;
    logic                    snap_onehot;
    logic [3:0]              dec_nibble;
    logic                    dec_blank;
    logic                    dec_illegal;
    logic [N_DIGITS-1:0]     wr_en;
    logic                    frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= SEG_OFF_RAW;
            seg_sync_q <= SEG_OFF_RAW;
            an_meta_q  <= AN_OFF_RAW;
            an_sync_q  <= AN_OFF_RAW;
        end else begin
            seg_meta_q <= seg_in;
            seg_sync_q <= seg_meta_q;
            an_meta_q  <= an_in;
            an_sync_q  <= an_meta_q;
        end
    end

    assign seg_on = SEG_ACTIVE_LOW ? ~seg_sync_q : seg_sync_q;
    assign an_on  = SEG_ACTIVE_LOW ? ~an_sync_q  : an_sync_q;
    assign cur    = {seg_on, an_on};

    assign snap_seg    = snap_q[SNAP_W-1 -: 7];
    assign snap_an     = snap_q[N_DIGITS-1:0];
    assign snap_onehot = $onehot(snap_an);
    assign cnt_inc     = cnt_q + CNT_W'(1);

    seg7_to_hex u_dec (
        .seg_i     (snap_seg),
        .nibble_o  (dec_nibble),
        .blank_o   (dec_blank),
        .illegal_o (dec_illegal)
    );

    // The count includes the cycle on which the snapshot was taken.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        sample_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (an_on != '0) begin
                    snap_d  = cur;
                    cnt_d   = CNT_W'(1);
                    state_d = (SETTLE_CYCLES <= 1) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (an_on == '0) begin
                    state_d = IDLE;
                end else if (cur == snap_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= SETTLE_LAST) begin
                        state_d = SAMPLE;
                    end
                end else begin
                    snap_d = cur;
                    cnt_d  = CNT_W'(1);
                end
            end
            SAMPLE: begin
                sample_go = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (cur != snap_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_wr
            assign wr_en[gi] = sample_go && snap_onehot && snap_an[gi];
        end
    endgenerate

    assign frame_done = &seen_q;

    // Completion cannot coincide with a sample: SAMPLE is always followed by HOLD.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        seen_d         = seen_q;
        err_acc_d      = err_acc_q;
        value_d        = value_q;
        blank_d        = blank_q;
        frame_valid_d  = frame_done;
        frame_err_d    = frame_err_q;

        if (frame_done) begin
            value_d     = shadow_val_q;
            blank_d     = shadow_blank_q;
            frame_err_d = err_acc_q;
            seen_d      = '0;
            err_acc_d   = 1'b0;
        end

        if (sample_go) begin
            if (!snap_onehot || dec_illegal) begin
                err_acc_d = 1'b1;
            end
            if (snap_onehot) begin
                seen_d = seen_q | snap_an;
            end
        end

        for (int i = 0; i < N_DIGITS; i++) begin
            if (wr_en[i]) begin
                shadow_val_d[i*4 +: 4] = dec_nibble;
                shadow_blank_d[i]      = dec_blank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            snap_q         <= '0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            seen_q         <= '0;
            err_acc_q      <= 1'b0;
            value_q        <= '0;
            blank_q        <= '0;
            frame_valid_q  <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            snap_q         <= snap_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            seen_q         <= seen_d;
            err_acc_q      <= err_acc_d;
            value_q        <= value_d;
            blank_q        <= blank_d;
            frame_valid_q  <= frame_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign value_o       = value_q;
    assign blank_o       = blank_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus emulates an active-low scanning display driver and
// queues the expected frame; a monitor checks every frame_valid_o pulse.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [7:0]  an_in;
    logic [31:0] value_o;
    logic [7:0]  blank_o;
    logic        frame_valid_o;
    logic        frame_err_o;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  blank;
        logic        err;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_e;
    int     pass_cnt  = 0;
    int     total_cnt = 0;
    int     frame_no  = 0;

    // Encoder side of the display path, abcdefg with segment on = 1.
    logic [6:0] seg_tbl [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .N_DIGITS       (8),
        .SETTLE_CYCLES  (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_in        (seg_in),
        .an_in         (an_in),
        .value_o       (value_o),
        .blank_o       (blank_o),
        .frame_valid_o (frame_valid_o),
        .frame_err_o   (frame_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] value, input logic [7:0] blank, input logic err);
        frame_t f;
        f.value = value;
        f.blank = blank;
        f.err   = err;
        exp_q.push_back(f);
    endtask

    // Drive an active-high view of the bus; the board polarity is active-low.
    task automatic drive(input logic [7:0] an_on, input logic [6:0] seg_on, input int cycles);
        an_in  = ~an_on;
        seg_in = ~seg_on;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic digit(input int k, input logic [3:0] nib, input int cycles);
        logic [7:0] an_on;
        an_on = 8'h01 << k;
        drive(an_on, seg_tbl[nib], cycles);
    endtask

    task automatic scan_word(input logic [31:0] word, input bit push);
        for (int k = 0; k < 8; k++) begin
            if (k == 7 && push) push_exp(word, 8'h00, 1'b0);
            digit(k, word[k*4 +: 4], 16);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, value_o, 32'h0);
        check({tag, "_blank"}, {24'h0, blank_o}, 32'h0);
        check({tag, "_valid"}, {31'h0, frame_valid_o}, 32'h0);
        check({tag, "_err"},   {31'h0, frame_err_o}, 32'h0);
    endtask

    // Monitor: every pulse must match the oldest queued frame.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_valid_o === 1'b1) begin
                frame_no++;
                $display("frame %0d: value=%h blank=%h err=%b", frame_no, value_o, blank_o, frame_err_o);
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_frame: got pulse with value %h, expected no pulse", value_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame_value", value_o, mon_e.value);
                    check("frame_blank", {24'h0, blank_o}, {24'h0, mon_e.blank});
                    check("frame_err", {31'h0, frame_err_o}, {31'h0, mon_e.err});
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        an_in  = 8'hFF;
        seg_in = 7'h7F;
        #1;
        check_reset_outputs("reset_start");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(8'h00, 7'h00, 5);

        // Round trip: two full scans of the same word.
        scan_word(32'h1234ABCD, 1'b1);
        scan_word(32'h1234ABCD, 1'b1);

        // Dark digit 0 and illegal code on digit 1, then a clean frame.
        drive(8'h01, 7'h00, 16);
        drive(8'h02, 7'h01, 16);
        for (int k = 2; k < 8; k++) begin
            if (k == 7) push_exp(32'h76543200, 8'h01, 1'b1);
            digit(k, 4'(k), 16);
        end
        scan_word(32'h89ABCDEF, 1'b1);

        // Digit 3 dwells only 3 cycles; the frame closes when it returns.
        for (int k = 0; k < 8; k++) begin
            if (k == 3) digit(3, 4'h0, 3);
            else        digit(k, 4'(8 + k), 16);
        end
        push_exp(32'hFEDCBA98, 8'h00, 1'b0);
        digit(3, 4'hB, 16);

        // Anodes dark: no pulse, outputs hold the last frame.
        drive(8'h00, 7'h00, 40);
        check("hold_value", value_o, 32'hFEDCBA98);

        // Two anodes at once: sample dropped, digits 0/1 keep E/F.
        digit(0, 4'hE, 16);
        digit(1, 4'hF, 16);
        drive(8'h03, seg_tbl[8], 16);
        for (int k = 2; k < 8; k++) begin
            if (k == 7) push_exp(32'h765432FE, 8'h00, 1'b1);
            digit(k, 4'(k), 16);
        end

        // Digit 2 shown twice (last wins); digit 5 glitches before settling on C.
        digit(0, 4'h0, 16);
        digit(1, 4'h1, 16);
        digit(2, 4'h5, 16);
        digit(3, 4'h3, 16);
        digit(2, 4'h9, 16);
        digit(4, 4'h4, 16);
        digit(5, 4'h7, 3);
        digit(5, 4'h8, 1);
        digit(5, 4'h7, 3);
        digit(5, 4'hC, 10);
        digit(6, 4'h6, 16);
        push_exp(32'h76C43910, 8'h00, 1'b0);
        digit(7, 4'h7, 16);

        // Reset while digit 4 is settling; the partial frame must be lost.
        for (int k = 0; k < 4; k++) digit(k, 4'h5, 16);
        digit(4, 4'h5, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        an_in  = 8'hFF;
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(8'h00, 7'h00, 5);
        for (int k = 4; k < 8; k++) digit(k, 4'(k), 16);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) push_exp(32'h76540123, 8'h00, 1'b0);
            digit(k, 4'(3 - k), 16);
        end

        drive(8'h00, 7'h00, 30);
        check("frames_outstanding", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
